// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : request FSM states (IDLE / REQ / DISCARD)
//   fetch_entry_t : one prefetch FIFO entry {pc, instr}
//   INSTR_NOP     : word presented downstream when nothing is valid
//   PC_STEP       : sequential PC increment in bytes
//   align_word()  : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small prefetch FIFO holding fetched {pc, instr} pairs.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push      : write wr_entry at the tail
//   pop       : drop the head entry
//   flush     : empty the FIFO (wins over push/pop)
//   wr_entry  : entry to write
//   head      : current head entry (combinational read, meaningful when count!=0)
//   count     : number of valid entries (0..DEPTH)
// ---------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  fetch_entry_t      wr_entry,
  output fetch_entry_t      head,
  output logic [CW-1:0]     count
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage needs no reset: entries are only observed through count.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: PC register, single-outstanding request FSM and
// a prefetch FIFO feeding the IF/DEC register.
// Ports:
//   Clock, Reset      : clock, asynchronous active-high reset
//   Stall             : decode hold, head entry is not consumed
//   BranchTaken       : redirect, flushes prefetched state
//   BranchAddr        : redirect target (low two bits ignored)
//   InstrReq          : memory request valid
//   InstrAddr         : memory request address
//   InstrReady        : memory accepts request, InstrData valid same cycle
//   InstrData         : fetched word
//   InstrOut, PCOut   : head instruction and its PC (zero when not valid)
//   ValidOut          : head entry valid
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchAddr,
  output logic        InstrReq,
  output logic [31:0] InstrAddr,
  input  logic        InstrReady,
  input  logic [31:0] InstrData,
  output logic [31:0] InstrOut,
  output logic [31:0] PCOut,
  output logic        ValidOut
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   pc;
  logic [31:0]   pc_next;
  logic [31:0]   discard_addr;
  logic [31:0]   discard_addr_next;
  logic [CW-1:0] count;
  logic [CW:0]   count_next;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          transfer;
  logic          push;
  logic          pop;
  logic          has_room;

  // An abandoned request keeps presenting its original address until the
  // memory takes it, even though the PC already points at the target.
  assign InstrReq  = (state == REQ) || (state == DISCARD);
  assign InstrAddr = (state == DISCARD) ? discard_addr : pc;

  assign transfer   = InstrReq & InstrReady;
  assign push       = transfer & (state == REQ) & ~BranchTaken;
  assign ValidOut   = (count != '0);
  assign pop        = ValidOut & ~Stall & ~BranchTaken;
  assign count_next = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
  assign has_room   = count_next < (CW+1)'(DEPTH);
  assign push_entry = '{pc: pc, instr: InstrData};

  assign InstrOut = ValidOut ? head.instr : INSTR_NOP;
  assign PCOut    = ValidOut ? head.pc    : 32'h0000_0000;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (Clock),
    .rst      (Reset),
    .push     (push),
    .pop      (pop),
    .flush    (BranchTaken),
    .wr_entry (push_entry),
    .head     (head),
    .count    (count)
  );

  // Next-state logic. A redirect overrides everything; otherwise the FSM
  // keeps one request in flight while the FIFO can absorb its result, and
  // leaves REQ only on a completed transfer.
  always_comb begin
    state_next        = state;
    pc_next           = pc;
    discard_addr_next = discard_addr;
    if (BranchTaken) begin
      pc_next = align_word(BranchAddr);
      unique case (state)
        IDLE: state_next = REQ;
        REQ: begin
          if (InstrReady) begin
            state_next = REQ;
          end else begin
            state_next        = DISCARD;
            discard_addr_next = pc;
          end
        end
        DISCARD: if (InstrReady) state_next = REQ;
        default: state_next = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: if (has_room) state_next = REQ;
        REQ: begin
          if (transfer) begin
            pc_next = pc + PC_STEP;
            if (!has_room) state_next = IDLE;
          end
        end
        DISCARD: if (InstrReady) state_next = REQ;
        default: state_next = IDLE;
      endcase
    end
  end

  // State registers; reset abandons any request in flight.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      discard_addr <= '0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      discard_addr <= discard_addr_next;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage with a program counter, a single-outstanding request/ready handshake to instruction memory, and a small prefetch FIFO. It feeds the IF-to-DEC pipeline register with an instruction word, its PC and a valid flag. It supports decode-side stall and an EX-side branch redirect that flushes all prefetched state.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2)

Clocking and reset: one clock; reset is asynchronous and active-high.

- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Stall  in  1  downstream hold; head entry is not consumed
- BranchTaken  in  1  redirect request, sampled on the rising edge
- BranchAddr  in  32  redirect target; bits [1:0] ignored and forced to 00
- InstrReq  out  1  memory request valid
- InstrAddr  out  32  request address; stable while InstrReq=1 and InstrReady=0
- InstrReady  in  1  memory accepts request; InstrData valid in the same cycle
- InstrData  in  32  fetched word
- InstrOut  out  32  head instruction; 32'h0000_0000 (NOP) when ValidOut=0
- PCOut  out  32  PC of head instruction; 0 when ValidOut=0
- ValidOut  out  1  head entry valid

## Operation
- States: IDLE (no request), REQ (InstrReq=1, address = PC), DISCARD (InstrReq=1, completing an abandoned request).
- Transfer: InstrReq & InstrReady. In REQ it pushes {InstrAddr, InstrData} and sets PC <= PC+4. PC wraps mod 2^32 (32'hFFFF_FFFC -> 0).
- Pop: ValidOut & ~Stall & ~BranchTaken.
- count_next = count + push − pop.
- IDLE -> REQ when count_next < DEPTH.
- REQ -> REQ when count_next < DEPTH; otherwise REQ -> IDLE. The exit to IDLE happens only on a transfer edge. The request is never withdrawn before InstrReady.
- BranchTaken, highest priority, applies on the edge where it is sampled:
  - FIFO flushed (count=0), and no pop occurs that cycle.
  - PC <= {BranchAddr[31:2],2'b00}.
  - If in REQ and InstrReady=0: go to DISCARD. InstrAddr holds the old address.
  - If InstrReady=1 in the branch cycle: the returned data is dropped and the state goes to REQ.
  - If in IDLE: go to REQ.
- DISCARD: on InstrReady, data is dropped and PC is not incremented; go to REQ. A further BranchTaken while in DISCARD only reloads PC.
- Stall with no branch: head is held; prefetch continues until the FIFO is full.
- Simultaneous push and pop at count=DEPTH is not possible, because no request is issued when full.
- Reset, asynchronous and possibly mid-handshake:
  - State IDLE, PC=RESET_PC, FIFO empty.
  - InstrReq=0, ValidOut=0, InstrOut=0, PCOut=0.
  - A memory response in flight is abandoned; memory must tolerate a request dropped by reset.

## Timing
- Edge 1 after reset release: IDLE -> REQ. InstrReq=1 during cycle 1 with InstrAddr=RESET_PC.
- With InstrReady=1 in cycle 1: ValidOut=1 after edge 2, so first-instruction latency is 2 edges.
- Steady state (InstrReady=1, Stall=0): one instruction per cycle. FIFO occupancy settles at 1.
- Branch sampled at edge N:
  - ValidOut=0 after N.
  - InstrAddr=target after N, provided no request was abandoned.
  - Target instruction valid after N+1 with zero-wait memory.
  - Each DISCARD wait cycle adds one cycle.
- All outputs come from registers or the FIFO head. There is no combinational path from InstrReady/InstrData to InstrOut.

## Structure
- Shared package fetch_pkg:
  - fetch_state_t enum {IDLE, REQ, DISCARD}
  - INSTR_NOP = 32'h0
  - PC_STEP = 4
  - fetch_entry_t struct {pc[31:0], instr[31:0]}
- Sub-module fetch_fifo: DEPTH × fetch_entry_t, synchronous push/pop/flush, count output, head read combinational.
- fetch_unit contains the PC register, the FSM and the handshake logic.

## Test plan
- Reset release, InstrReady tied 1, Stall=0 -> InstrAddr 0,4,8,…; ValidOut=1 from the cycle after edge 2; PCOut/InstrOut sequence matches the memory model with no gaps.
- Stall=1 for 5 cycles from PC=0x10 -> head stays 0x10; InstrReq drops after 2 prefetches (FIFO full); after release, 0x14, 0x18 follow with no loss or duplication.
- BranchTaken to 0x1003 while InstrReq=1, InstrReady=0 (address 0x40) -> DISCARD, InstrAddr held 0x40 until Ready, data dropped; next request 0x1000; PCOut 0x40 never appears.
- BranchTaken coincident with InstrReady and Stall=1 -> data dropped, FIFO flushed, ValidOut=0 next cycle, next request at target.
- Start with RESET_PC=32'hFFFF_FFF8 and zero-wait memory -> PCOut FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted mid-request with random wait states -> all outputs take reset values immediately; fetch restarts cleanly from RESET_PC.
